ap_pass_sequencer: RTL

Sequences compare/write passes on the CAM array to run bit-serial associative operations in place. Supported operations are multi-bit addition (B ← A + B, with carry in a dedicated column) and column-range clear. Each pass drives a key/mask compare, latches the resulting tag vector, then issues a tag-guided parallel write (CAM mode 1). The block sits between the AP command front-end and the CAM, and owns the CAM's key, mask, data and write-mode inputs while busy.

---
 rtl/ap_pkg.sv | 15 +
 rtl/ap_pattern_gen.sv | 32 +++
 rtl/ap_pass_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ap_pkg.sv
// ap_pkg: shared types and pass ROM for the associative-processing pass sequencer
package ap_pkg;
    typedef enum logic {OP_ADD = 1'b0, OP_CLEAR = 1'b1} op_t;
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_CMP, S_WR, S_DONE} state_t;
    typedef struct packed {
        logic kc;
        logic ka;
        logic kb;
        logic wc;
        logic wb;
        logic wce;
    } pass_t;
    // one full-adder step on (C, A_i, B_i); the order keeps a rewritten row from matching a later pass
    localparam pass_t PASS_ROM [4] = '{6'b011101, 6'b010010, 6'b100011, 6'b101000};
endpackage

// File: rtl/ap_pattern_gen.sv
// ap_pattern_gen: expands (pass, bit, bases, carry column) into CAM key/mask/data vectors
module ap_pattern_gen
    import ap_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int C_COL = WORD_SIZE - 1
) (
    input  logic                         op,
    input  logic                         pre,
    input  logic [1:0]                   pass,
    input  logic [$clog2(WORD_SIZE)-1:0] bit_idx,
    input  logic [$clog2(WORD_SIZE)-1:0] a_base,
    input  logic [$clog2(WORD_SIZE)-1:0] b_base,
    input  logic [$clog2(WORD_SIZE)-1:0] width,
    output logic [WORD_SIZE-1:0]         key,
    output logic [WORD_SIZE-1:0]         cmp_mask,
    output logic [WORD_SIZE-1:0]         wr_mask,
    output logic [WORD_SIZE-1:0]         dina
);
    pass_t p;
    logic [WORD_SIZE-1:0] c_oh, a_oh, b_oh, b_rng;
    assign p = PASS_ROM[pass];
    assign c_oh = WORD_SIZE'(1) << C_COL;
    assign a_oh = WORD_SIZE'(1) << (a_base + bit_idx);
    assign b_oh = WORD_SIZE'(1) << (b_base + bit_idx);
    assign b_rng = ((WORD_SIZE'(1) << width) - WORD_SIZE'(1)) << b_base;
    // the pre pass compares nothing so every row tags, then clears carry or the B range
    assign key = pre ? '0 : ({WORD_SIZE{p.kc}} & c_oh) | ({WORD_SIZE{p.ka}} & a_oh) | ({WORD_SIZE{p.kb}} & b_oh);
    assign cmp_mask = pre ? '0 : c_oh | a_oh | b_oh;
    assign wr_mask = pre ? (op == OP_CLEAR ? b_rng : c_oh) : b_oh | ({WORD_SIZE{p.wce}} & c_oh);
    assign dina = pre ? '0 : ({WORD_SIZE{p.wc}} & c_oh) | ({WORD_SIZE{p.wb}} & b_oh);
endmodule

// File: rtl/ap_pass_sequencer.sv
// ap_pass_sequencer: runs CAM compare/write passes for in-place bit-serial ADD and column-range CLEAR.
// Define AP_SKIP_EMPTY_EN to drop the write of any pass whose compare tagged no rows.
module ap_pass_sequencer
    import ap_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int CELL_QUANT = 128,
    parameter int C_COL = WORD_SIZE - 1
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_op,
    input  logic [$clog2(WORD_SIZE)-1:0] cmd_a_base,
    input  logic [$clog2(WORD_SIZE)-1:0] cmd_b_base,
    input  logic [$clog2(WORD_SIZE)-1:0] cmd_width,
    input  logic [CELL_QUANT-1:0]        cam_tags,
    output logic [WORD_SIZE-1:0]         cam_key,
    output logic [WORD_SIZE-1:0]         cam_mask,
    output logic [WORD_SIZE-1:0]         cam_dina,
    output logic                         cam_mode,
    output logic [CELL_QUANT-1:0]        cam_wea_ap,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    localparam int AW = $clog2(WORD_SIZE);
    state_t state, state_n;
    op_t op;
    logic [AW-1:0] a_base, b_base, width, bit_idx;
    logic [1:0] pass;
    logic pre, err_q, accept, advance, last, bad, skip;
    logic [CELL_QUANT-1:0] tag_q;
    logic [AW:0] a_end, b_end, c_col;
    logic [WORD_SIZE-1:0] key, cmp_mask, wr_mask, dina;

    ap_pattern_gen #(.WORD_SIZE(WORD_SIZE), .C_COL(C_COL)) u_pat (
        .op(op), .pre(pre), .pass(pass), .bit_idx(bit_idx), .a_base(a_base), .b_base(b_base),
        .width(width), .key(key), .cmp_mask(cmp_mask), .wr_mask(wr_mask), .dina(dina)
    );

    assign a_end = {1'b0, a_base} + {1'b0, width};
    assign b_end = {1'b0, b_base} + {1'b0, width};
    assign c_col = (AW+1)'(C_COL);
    assign bad = width == '0 || b_end > (AW+1)'(WORD_SIZE) || (op == OP_ADD && (a_end > (AW+1)'(WORD_SIZE)
               || ({1'b0, a_base} < b_end && {1'b0, b_base} < a_end)
               || (c_col >= {1'b0, a_base} && c_col < a_end)
               || (c_col >= {1'b0, b_base} && c_col < b_end)));
    assign last = pre ? op == OP_CLEAR : pass == 2'd3 && bit_idx == width - AW'(1);
`ifdef AP_SKIP_EMPTY_EN
    assign skip = cam_tags == '0;
`else
    assign skip = 1'b0;
`endif
    assign cmd_ready = state == S_IDLE && !rst;
    assign accept = cmd_valid && cmd_ready;
    assign busy = state != S_IDLE;
    assign done = state == S_DONE;
    assign err = done && err_q;
    assign cam_mode = state == S_WR;
    assign cam_key = state == S_CMP ? key : '0;
    assign cam_mask = state == S_CMP ? cmp_mask : cam_mode ? wr_mask : '0;
    assign cam_dina = cam_mode ? dina : '0;
    assign cam_wea_ap = cam_mode ? tag_q : '0;

    always_comb begin
        state_n = state;
        advance = 1'b0;
        case (state)
            S_IDLE:  state_n = accept ? S_CHECK : S_IDLE;
            S_CHECK: state_n = bad ? S_DONE : S_CMP;
            S_CMP: begin
                advance = skip;
                state_n = skip ? (last ? S_DONE : S_CMP) : S_WR;
            end
            S_WR: begin
                advance = 1'b1;
                state_n = last ? S_DONE : S_CMP;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= S_IDLE;
            op <= OP_ADD;
            a_base <= '0;
            b_base <= '0;
            width <= '0;
            bit_idx <= '0;
            pass <= '0;
            pre <= 1'b0;
            err_q <= 1'b0;
            tag_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op <= op_t'(cmd_op);
                a_base <= cmd_a_base;
                b_base <= cmd_b_base;
                width <= cmd_width;
                err_q <= 1'b0;
            end
            if (state == S_CHECK) begin
                err_q <= bad;
                pre <= 1'b1;
                pass <= '0;
                bit_idx <= '0;
            end
            if (state == S_CMP) tag_q <= cam_tags;
            if (advance) begin
                pre <= 1'b0;
                pass <= pre ? 2'd0 : pass + 2'd1;
                if (!pre && pass == 2'd3) bit_idx <= bit_idx + AW'(1);
            end
        end
    end
endmodule
